// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Integer-truncated clock cycles per line bit; the receiver uses the same rounding.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit timer: one-cycle bit_tick every CLKS_PER_BIT cycles, restartable by clear.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Clearing on acceptance lines every bit boundary up with the start edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: parallel word in, start / data LSB first / [parity] / stop frame out on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and the stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2, got %0d", STOP_BITS);
    end

    uart_tx_state_t        state, state_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic                  tx_n, done_n, accept, bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                  par, par_n;
`endif

    // Handshake: a word is taken on the rising edge where valid && ready; ready is high
    // only in IDLE, and valid while a frame is in flight is dropped rather than queued.
    assign ready  = (state == IDLE);
    assign accept = ready && valid;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shift <= '0;
            idx   <= '0;
            tx    <= 1'b1;
            done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            shift <= shift_n;
            idx   <= idx_n;
            tx    <= tx_n;
            done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        done_n  = 1'b0;
        tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (valid) begin
                    shift_n = data_in;
                    idx_n   = '0;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_tick) state_n = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_n = shift >> 1;
                    if (idx == LAST_DATA) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) state_n = STOP;
            end
`endif
            STOP: begin
                // idx is reused here to count stop bits.
                if (bit_tick) begin
                    if (idx == LAST_STOP) begin
                        idx_n   = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next state so the line changes on the same edge as the FSM.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast instance (17 clocks/bit, 2 stop bits) under random and directed
// traffic checked by a line-decoding monitor against a frame model, plus one default-parameter frame.
module tb_uart_tx;

    localparam int DW        = 8;
    localparam int FAST_FREQ = 2_000_000;
    localparam int BAUD      = 115200;
    localparam int C         = FAST_FREQ / BAUD;
    localparam int SB        = 2;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB     = 1 + DW + P + SB;
    localparam int F      = NB * C;
    localparam int C_DEF  = 868;
    localparam int NB_DEF = 1 + DW + P + 1;
    localparam int F_DEF  = NB_DEF * C_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] d_data = '0;
    logic          valid = 1'b0;
    logic          d_valid = 1'b0;
    logic          ready, tx, done;
    logic          d_ready, d_tx, d_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pushed = 0;
    int done_total = 0;
    int done_run = 0;
    int max_done_run = 0;
    logic [15:0] exp_q[$];
    int fall_q[$];
    int done_q[$];

    uart_tx #(
        .DATA_WIDTH(DW), .CLK_FREQ(FAST_FREQ), .BAUD_RATE(BAUD), .STOP_BITS(SB)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready), .tx(tx), .done(done)
    );

    uart_tx #(
        .DATA_WIDTH(DW)
    ) dut_def (
        .clk(clk), .rst(rst), .data_in(d_data), .valid(d_valid),
        .ready(d_ready), .tx(d_tx), .done(d_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Frame as line bits, bit 0 first: start 0, data LSB first, optional even parity, stop 1s.
    function automatic logic [15:0] frame_of(input logic [DW-1:0] d, input int stops);
        logic [15:0] f;
        f = '0;
        for (int i = 0; i < DW; i++) f[1 + i] = d[i];
        if (P == 1) f[1 + DW] = ^d;
        for (int s = 0; s < stops; s++) f[1 + DW + P + s] = 1'b1;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit hold);
        int w;
        data_in = d;
        valid   = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            w++;
            if (w > 4 * F) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: ready never rose for 0x%0h", d);
                valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        exp_q.push_back(frame_of(d, SB));
        pushed++;
        #1;
        if (!hold) valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (done_total < pushed && w < 4 * F * (pushed - done_total + 1)) begin
            @(negedge clk);
            w++;
        end
        check("drain_done_count", done_total, pushed);
        idle(1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        tx_prev;
        logic [15:0] exp, got;
        int          bad;
        bit          have, aborted, early;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst || !(tx_prev === 1'b1 && tx === 1'b0)) begin
                tx_prev = tx;
                continue;
            end
            fall_q.push_back(cyc);
            have = (exp_q.size() != 0);
            exp  = have ? exp_q.pop_front() : 16'h0;
            got = '0;
            bad = 0;
            aborted = 1'b0;
            early = 1'b0;
            for (int j = 0; j < F; j++) begin
                if (j > 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx !== exp[j / C]) bad++;
                if (j % C == C / 2) got[j / C] = tx;
                if (done === 1'b1) early = 1'b1;
            end
            if (!aborted) begin
                @(negedge clk);
                if (rst) aborted = 1'b1;
            end
            if (!aborted) begin
                done_q.push_back(cyc);
                check("frame_expected", {31'd0, have}, 32'd1);
                check("frame_bits", {16'd0, got}, {16'd0, exp});
                check("line_samples_off", bad, 0);
                check("done_early", {31'd0, early}, 32'd0);
                check("done_at_frame_end", {31'd0, done}, 32'd1);
                check("ready_at_done", {31'd0, ready}, 32'd1);
            end
            tx_prev = tx;
        end
    end

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_run++;
            if (done_run == 1) done_total++;
        end else begin
            done_run = 0;
        end
        if (done_run > max_done_run) max_done_run = done_run;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nf, nd, w, len;
        bit saw_done, hold;
        logic [15:0] got;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_tx", {31'd0, tx}, 32'd1);
            check("reset_ready", {31'd0, ready}, 32'd1);
            check("reset_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_tx", {31'd0, tx}, 32'd1);
        check("post_reset_ready", {31'd0, ready}, 32'd1);
        check("post_reset_def_tx", {31'd0, d_tx}, 32'd1);
        idle(1);

        // single frame
        send(8'h58, 1'b0);
        @(negedge clk);
        check("accept_tx_low", {31'd0, tx}, 32'd0);
        check("accept_ready_low", {31'd0, ready}, 32'd0);
        drain();

        // back-to-back with valid held
        nf = fall_q.size();
        nd = done_q.size();
        send(8'h37, 1'b1);
        send(8'h23, 1'b0);
        drain();
        if (fall_q.size() >= nf + 2 && done_q.size() >= nd + 1)
            check("b2b_gap", fall_q[nf + 1] - done_q[nd], 1);
        else
            check("b2b_frames_seen", fall_q.size() - nf, 2);

        // valid while busy is ignored
        send(8'h55, 1'b0);
        idle(3 * C);
        data_in = 8'hFF;
        valid   = 1'b1;
        idle(1);
        valid   = 1'b0;
        drain();

        // reset during data bit 3 aborts the frame
        nd = done_total;
        data_in = 8'hA5;
        valid   = 1'b1;
        idle(1);
        valid   = 1'b0;
        idle(4 * C + C / 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx_high", {31'd0, tx}, 32'd1);
        check("abort_ready", {31'd0, ready}, 32'd1);
        idle(2);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 3 * C; i++) begin
            @(negedge clk);
            if (done === 1'b1 || tx !== 1'b1) saw_done = 1'b1;
        end
        check("abort_quiet_line_no_done", {31'd0, saw_done}, 32'd0);
        check("abort_done_count", done_total, nd);
        idle(1);
        send(8'h3C, 1'b0);
        drain();

        // random traffic
        for (int i = 0; i < 10; i++) begin
            hold = (i < 9) && ($urandom_range(0, 2) == 0);
            send(8'($urandom_range(0, 255)), hold);
            if (!hold) idle($urandom_range(0, 2 * C));
        end
        drain();

        // default parameters: 868 clocks per bit
        d_data  = 8'h58;
        d_valid = 1'b1;
        idle(1);
        d_valid = 1'b0;
        got = '0;
        len = -1;
        w = 0;
        while (w < F_DEF + 20) begin
            @(negedge clk);
            if (w % C_DEF == C_DEF / 2 && w / C_DEF < NB_DEF) got[w / C_DEF] = d_tx;
            if (d_done === 1'b1) begin
                len = w;
                break;
            end
            w++;
        end
        check("def_frame_bits", {16'd0, got}, {16'd0, frame_of(8'h58, 1)});
        check("def_frame_len", len, F_DEF);
        check("def_ready_at_done", {31'd0, d_ready}, 32'd1);
        @(negedge clk);
        check("def_done_one_cycle", {31'd0, d_done}, 32'd0);

        idle(2);
        check("final_done_count", done_total, pushed);
        check("final_done_width", max_done_run, 1);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
